// File: rtl/stack_pkg.sv
// Shared types and sizing for the 5-entry stack core
// and its host-side driver.
package stack_pkg;

  localparam int STACK_DEPTH = 5;
  localparam int DATA_W = 4;
  localparam int IDX_W = 3;
  localparam logic [2:0] DEPTH_C = 3'(STACK_DEPTH);

  typedef enum logic [1:0] {
    CMD_NOP,
    CMD_PUSH,
    CMD_POP,
    CMD_GET
  } cmd_t;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_t;

  // Requests that would corrupt the core never reach it
  function automatic logic reject(
    input cmd_t c,
    input logic [IDX_W-1:0] idx,
    input logic [2:0] cnt
  );
    unique case (c)
      CMD_PUSH: reject = (cnt == DEPTH_C);
      CMD_POP:  reject = (cnt == 3'd0);
      CMD_GET:  reject = (idx >= cnt);
      default:  reject = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stack_host_driver_if.sv
// Request/response channels between a host and
// the stack driver.
interface stack_host_driver_if;
  import stack_pkg::*;

  logic              req_valid;
  logic              req_ready;
  cmd_t              req_cmd;
  logic [IDX_W-1:0]  req_index;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_cmd, req_index,
    output req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_err
  );

  modport slave (
    input  req_valid, req_cmd, req_index,
    input  req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_err
  );

endinterface

// File: rtl/stack_bus_pad.sv
// One bit of the shared stack IO bus: tristate
// driver plus input sampler.
module stack_bus_pad (
  input  logic oe,
  input  logic dout,
  output logic din,
  inout  wire  pad
);

  assign pad = oe ? dout : 1'bz;
  assign din = pad;

endmodule

// File: rtl/stack_host_driver.sv
// Sequencer that turns valid/ready stack requests
// into setup-strobe-hold cycles on the core pins.
module stack_host_driver
  import stack_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  stack_host_driver_if.slave bus,
  output logic [2:0]        count,
  output logic              STK_CLK,
  output logic              STK_RESET,
  output logic [1:0]        STK_COMMAND,
  output logic [IDX_W-1:0]  STK_INDEX,
  inout  wire  [DATA_W-1:0] STK_IO
);

  state_t            state;
  cmd_t              cmd_q;
  cmd_t              stk_cmd;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] din;
  logic              oe;

  assign STK_COMMAND = stk_cmd;

  for (genvar i = 0; i < DATA_W; i++) begin : g_pad
    stack_bus_pad u_pad (
      .oe   (oe),
      .dout (data_q[i]),
      .din  (din[i]),
      .pad  (STK_IO[i])
    );
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= RST_HOLD;
      cmd_q         <= CMD_NOP;
      data_q        <= '0;
      stk_cmd       <= CMD_NOP;
      STK_INDEX     <= '0;
      STK_CLK       <= 1'b0;
      STK_RESET     <= 1'b1;
      oe            <= 1'b0;
      count         <= 3'd0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        RST_HOLD: begin
          STK_RESET     <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            bus.rsp_data  <= '0;
            cmd_q         <= bus.req_cmd;
            data_q        <= bus.req_data;
            if (reject(bus.req_cmd, bus.req_index,
                       count)) begin
              bus.rsp_err   <= 1'b1;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end else begin
              bus.rsp_err <= 1'b0;
              stk_cmd     <= bus.req_cmd;
              STK_INDEX   <= bus.req_index;
              oe          <= (bus.req_cmd == CMD_PUSH);
              state       <= SETUP;
            end
          end
        end
        SETUP: begin
          STK_CLK <= 1'b1;
          state   <= STROBE;
        end
        STROBE: begin
          STK_CLK <= 1'b0;
          state   <= HOLD;
          unique case (cmd_q)
            CMD_PUSH: count <= count + 3'd1;
            CMD_POP: begin
              count        <= count - 3'd1;
              bus.rsp_data <= din;
            end
            CMD_GET: bus.rsp_data <= din;
            default: ;
          endcase
        end
        HOLD: begin
          stk_cmd       <= CMD_NOP;
          STK_INDEX     <= '0;
          oe            <= 1'b0;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
